// File: rtl/instruction_prefetch_unit.sv
// Sequential instruction prefetcher: req/ack fetch into a small FIFO,
// with flush redirect and discard of a stale in-flight request.
module instruction_prefetch_unit #(
  parameter int OPERAND_WIDTH     = 11,
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int DEPTH             = 4
) (
  input  logic                         clock_in,
  input  logic                         reset_in,
  output logic                         mem_req_out,
  output logic [OPERAND_WIDTH-1:0]     mem_addr_out,
  input  logic                         mem_ack_in,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_data_in,
  input  logic                         flush_in,
  input  logic [OPERAND_WIDTH-1:0]     flush_address_in,
  output logic                         instr_valid_out,
  input  logic                         instr_ready_in,
  output logic [INSTRUCTION_WIDTH-1:0] instruction_out,
  output logic [OPERAND_WIDTH-1:0]     instruction_address_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  state_t state, state_nxt;

  logic [OPERAND_WIDTH-1:0]     fetch_addr, req_addr;
  logic [INSTRUCTION_WIDTH-1:0] data_q [DEPTH];
  logic [OPERAND_WIDTH-1:0]     addr_q [DEPTH];
  logic [PW-1:0]                rd_ptr, wr_ptr, rd_inc;
  logic [CW-1:0]                count, count_nxt;
  logic                         push, pop;

  assign push      = (state == REQ) && mem_ack_in && !flush_in;
  assign pop       = (count != '0) && instr_ready_in && !flush_in;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign rd_inc    = rd_ptr + PW'(1);

  assign instr_valid_out = (count != '0);

  always_ff @(posedge clock_in) begin
    if (!reset_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (flush_in || count != FULL) state_nxt = REQ;
      end
      REQ: begin
        if (flush_in)        state_nxt = mem_ack_in ? REQ : DISCARD;
        else if (mem_ack_in) state_nxt = (count_nxt != FULL) ? REQ : IDLE;
      end
      DISCARD: begin
        if (mem_ack_in) state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // DISCARD keeps presenting the stale address until memory acks it
  always_comb begin
    mem_req_out  = 1'b0;
    mem_addr_out = '0;
    unique case (state)
      REQ: begin
        mem_req_out  = 1'b1;
        mem_addr_out = fetch_addr;
      end
      DISCARD: begin
        mem_req_out  = 1'b1;
        mem_addr_out = req_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in && push) begin
      data_q[wr_ptr] <= mem_data_in;
      addr_q[wr_ptr] <= fetch_addr;
    end
  end

  always_ff @(posedge clock_in) begin
    if (!reset_in) begin
      fetch_addr              <= '0;
      req_addr                <= '0;
      count                   <= '0;
      rd_ptr                  <= '0;
      wr_ptr                  <= '0;
      instruction_out         <= '0;
      instruction_address_out <= '0;
    end else begin
      if (state == REQ) req_addr <= fetch_addr;
      if (flush_in) begin
        fetch_addr <= flush_address_in;
        count      <= '0;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
      end else begin
        count <= count_nxt;
        if (push) begin
          fetch_addr <= fetch_addr + OPERAND_WIDTH'(1);
          wr_ptr     <= wr_ptr + PW'(1);
        end
        if (pop) rd_ptr <= rd_inc;
        // head register tracks the entry that will be at rd_ptr
        if (push && count == CW'(pop)) begin
          instruction_out         <= mem_data_in;
          instruction_address_out <= fetch_addr;
        end else if (pop && count_nxt != '0) begin
          instruction_out         <= data_q[rd_inc];
          instruction_address_out <= addr_q[rd_inc];
        end
      end
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit: fetch, stall, flush,
// discard, wrap and mid-request reset.
module tb_instruction_prefetch_unit;

  logic        clock_in;
  logic        reset_in;
  logic        mem_req_out;
  logic [10:0] mem_addr_out;
  logic        mem_ack_in;
  logic [15:0] mem_data_in;
  logic        flush_in;
  logic [10:0] flush_address_in;
  logic        instr_valid_out;
  logic        instr_ready_in;
  logic [15:0] instruction_out;
  logic [10:0] instruction_address_out;

  int checks = 0;
  int errors = 0;

  instruction_prefetch_unit #(
    .OPERAND_WIDTH(11),
    .INSTRUCTION_WIDTH(16),
    .DEPTH(4)
  ) dut (
    .clock_in(clock_in),
    .reset_in(reset_in),
    .mem_req_out(mem_req_out),
    .mem_addr_out(mem_addr_out),
    .mem_ack_in(mem_ack_in),
    .mem_data_in(mem_data_in),
    .flush_in(flush_in),
    .flush_address_in(flush_address_in),
    .instr_valid_out(instr_valid_out),
    .instr_ready_in(instr_ready_in),
    .instruction_out(instruction_out),
    .instruction_address_out(instruction_address_out)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // memory answers with 16'h1000 + requested address
  task automatic cyc(input logic a);
    mem_ack_in  = a;
    mem_data_in = 16'h1000 + 16'(mem_addr_out);
    @(posedge clock_in);
    #1;
  endtask

  initial begin
    reset_in         = 1'b0;
    mem_ack_in       = 1'b0;
    mem_data_in      = '0;
    flush_in         = 1'b0;
    flush_address_in = '0;
    instr_ready_in   = 1'b0;
    #1;
    cyc(0);
    cyc(0);
    chk("rst_req",   32'(mem_req_out), 32'h0);
    chk("rst_valid", 32'(instr_valid_out), 32'h0);
    chk("rst_maddr", 32'(mem_addr_out), 32'h0);
    chk("rst_instr", 32'(instruction_out), 32'h0);
    chk("rst_iaddr", 32'(instruction_address_out), 32'h0);

    reset_in = 1'b1;
    cyc(0);
    chk("e1_req",   32'(mem_req_out), 32'h1);
    chk("e1_maddr", 32'(mem_addr_out), 32'h0);
    chk("e1_valid", 32'(instr_valid_out), 32'h0);
    cyc(1);
    chk("e2_valid", 32'(instr_valid_out), 32'h1);
    chk("e2_instr", 32'(instruction_out), 32'h1000);
    chk("e2_iaddr", 32'(instruction_address_out), 32'h0);
    chk("e2_maddr", 32'(mem_addr_out), 32'h1);
    cyc(1);
    chk("e3_maddr", 32'(mem_addr_out), 32'h2);
    cyc(1);
    chk("e4_maddr", 32'(mem_addr_out), 32'h3);
    cyc(1);
    chk("full_req",   32'(mem_req_out), 32'h0);
    chk("full_valid", 32'(instr_valid_out), 32'h1);
    chk("full_instr", 32'(instruction_out), 32'h1000);
    cyc(0);
    chk("idle_req", 32'(mem_req_out), 32'h0);

    instr_ready_in = 1'b1;
    cyc(0);
    instr_ready_in = 1'b0;
    chk("pop_instr", 32'(instruction_out), 32'h1001);
    chk("pop_iaddr", 32'(instruction_address_out), 32'h1);
    chk("pop_req",   32'(mem_req_out), 32'h0);
    cyc(0);
    chk("refetch_req",   32'(mem_req_out), 32'h1);
    chk("refetch_maddr", 32'(mem_addr_out), 32'h4);

    cyc(0);
    flush_in         = 1'b1;
    flush_address_in = 11'h200;
    cyc(0);
    flush_in = 1'b0;
    chk("dis_req",   32'(mem_req_out), 32'h1);
    chk("dis_maddr", 32'(mem_addr_out), 32'h4);
    chk("dis_valid", 32'(instr_valid_out), 32'h0);
    cyc(1);
    chk("redir_maddr", 32'(mem_addr_out), 32'h200);
    chk("redir_valid", 32'(instr_valid_out), 32'h0);
    cyc(1);
    chk("redir_hvalid", 32'(instr_valid_out), 32'h1);
    chk("redir_iaddr",  32'(instruction_address_out), 32'h200);
    chk("redir_instr",  32'(instruction_out), 32'h1200);
    chk("redir_next",   32'(mem_addr_out), 32'h201);
    cyc(1);

    instr_ready_in   = 1'b1;
    flush_in         = 1'b1;
    flush_address_in = 11'h7FE;
    cyc(1);
    instr_ready_in = 1'b0;
    flush_in       = 1'b0;
    chk("fa_valid", 32'(instr_valid_out), 32'h0);
    chk("fa_req",   32'(mem_req_out), 32'h1);
    chk("fa_maddr", 32'(mem_addr_out), 32'h7FE);

    cyc(1);
    chk("w_iaddr", 32'(instruction_address_out), 32'h7FE);
    chk("w_instr", 32'(instruction_out), 32'h17FE);
    chk("w_maddr1", 32'(mem_addr_out), 32'h7FF);
    cyc(1);
    chk("w_maddr2", 32'(mem_addr_out), 32'h000);
    cyc(1);
    chk("w_maddr3", 32'(mem_addr_out), 32'h001);
    instr_ready_in = 1'b1;
    cyc(0);
    chk("w_pop1_iaddr", 32'(instruction_address_out), 32'h7FF);
    chk("w_pop1_instr", 32'(instruction_out), 32'h17FF);
    cyc(0);
    instr_ready_in = 1'b0;
    chk("w_pop2_iaddr", 32'(instruction_address_out), 32'h000);
    chk("w_pop2_instr", 32'(instruction_out), 32'h1000);

    cyc(1);
    cyc(1);
    chk("mr_valid", 32'(instr_valid_out), 32'h1);
    chk("mr_maddr", 32'(mem_addr_out), 32'h3);
    reset_in = 1'b0;
    cyc(1);
    chk("rr_req",   32'(mem_req_out), 32'h0);
    chk("rr_valid", 32'(instr_valid_out), 32'h0);
    chk("rr_maddr", 32'(mem_addr_out), 32'h0);
    chk("rr_iaddr", 32'(instruction_address_out), 32'h0);
    chk("rr_instr", 32'(instruction_out), 32'h0);
    reset_in = 1'b1;
    cyc(0);
    chk("rs_req",   32'(mem_req_out), 32'h1);
    chk("rs_maddr", 32'(mem_addr_out), 32'h0);
    cyc(1);
    chk("rs_valid", 32'(instr_valid_out), 32'h1);
    chk("rs_iaddr", 32'(instruction_address_out), 32'h0);
    chk("rs_instr", 32'(instruction_out), 32'h1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
